// File: rtl/handshake_fifo_buffer_if.sv
// Valid/ready channel pair for the elastic FIFO buffer: input token channel plus output token channel.
interface handshake_fifo_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] outs;
  logic                  outs_valid;
  logic                  outs_ready;

  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid
  );

  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid
  );
endinterface

// File: rtl/handshake_fifo_buffer.sv
// Elastic in-order FIFO on a valid/ready channel; ready/valid come from registered state only.
// Optional zero-latency empty bypass enabled by defining HANDSHAKE_FIFO_BYPASS_EN.
module handshake_fifo_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  handshake_fifo_buffer_if.slave       bus,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wp;
  logic [PTR_W-1:0]      rp;
  logic [CNT_W-1:0]      occ;

  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  ready_c;
  logic                  valid_c;
  logic [DATA_WIDTH-1:0] data_c;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (occ == '0);
  assign full    = (occ == CNT_W'(DEPTH));
  // Ready never looks at outs_ready, so a full buffer refuses even when popping.
  assign ready_c = rst && !full;

`ifdef HANDSHAKE_FIFO_BYPASS_EN
  // Empty buffer forwards the input token combinationally; it is stored only if not taken.
  assign valid_c = empty ? (rst && bus.ins_valid) : 1'b1;
  assign data_c  = !valid_c ? '0 : (empty ? bus.ins : mem[rp]);
  assign push    = bus.ins_valid && ready_c && !(empty && bus.outs_ready);
  assign pop     = !empty && bus.outs_ready;
`else
  assign valid_c = !empty;
  assign data_c  = empty ? '0 : mem[rp];
  assign push    = bus.ins_valid && ready_c;
  assign pop     = valid_c && bus.outs_ready;
`endif

  assign bus.ins_ready  = ready_c;
  assign bus.outs_valid = valid_c;
  assign bus.outs       = data_c;
  assign count          = occ;

  // Pointer and occupancy state; reset discards tokens without touching storage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (push) wp <= next_ptr(wp);
      if (pop)  rp <= next_ptr(rp);
      case ({push, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= bus.ins;
  end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Directed self-checking bench for handshake_fifo_buffer (DEPTH=4, DATA_WIDTH=32).
module tb_handshake_fifo_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] count;
  int         checks   = 0;
  int         failures = 0;

  handshake_fifo_buffer_if #(.DATA_WIDTH(32)) bus ();

  handshake_fifo_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.ins_valid = 1'b1; bus.ins = 32'h3B6; bus.outs_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.outs_valid !== 1'b0) begin failures++; $display("FAIL reset_outs_valid cyc=%0d got=%b exp=0", i, bus.outs_valid); end
      checks++; if (bus.outs !== 32'h0) begin failures++; $display("FAIL reset_outs cyc=%0d got=%h exp=0", i, bus.outs); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count cyc=%0d got=%0d exp=0", i, count); end
      checks++; if (bus.ins_ready !== 1'b0) begin failures++; $display("FAIL reset_ins_ready cyc=%0d got=%b exp=0", i, bus.ins_ready); end
    end
    rst = 1'b1; bus.ins_valid = 1'b0;
    #1;
    checks++; if (bus.ins_ready !== 1'b1) begin failures++; $display("FAIL release_ins_ready got=%b exp=1", bus.ins_ready); end
    step();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL release_count got=%0d exp=0", count); end
  endtask

  task automatic test_fill_and_drain();
    logic [31:0] exp_tok [4];
    exp_tok[0] = 32'h3B6; exp_tok[1] = 32'h001; exp_tok[2] = 32'h002; exp_tok[3] = 32'h003;
    bus.outs_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ins = exp_tok[i]; bus.ins_valid = 1'b1;
      step();
      checks++; if (count !== 3'(i + 1)) begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i + 1); end
      checks++; if (bus.outs !== 32'h3B6) begin failures++; $display("FAIL fill_head i=%0d got=%h exp=3b6", i, bus.outs); end
    end
    checks++; if (bus.ins_ready !== 1'b0) begin failures++; $display("FAIL full_ins_ready got=%b exp=0", bus.ins_ready); end
    bus.ins = 32'h004;
    step(); step();
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_hold_count got=%0d exp=4", count); end
    bus.ins_valid = 1'b0; bus.outs_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.outs !== exp_tok[i] || bus.outs_valid !== 1'b1) begin failures++; $display("FAIL drain_tok i=%0d got=%h v=%b exp=%h", i, bus.outs, bus.outs_valid, exp_tok[i]); end
      step();
    end
    checks++; if (bus.outs_valid !== 1'b0) begin failures++; $display("FAIL drain_empty_valid got=%b exp=0", bus.outs_valid); end
    checks++; if (bus.outs !== 32'h0) begin failures++; $display("FAIL drain_empty_outs got=%h exp=0", bus.outs); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL drain_empty_count got=%0d exp=0", count); end
    bus.outs_ready = 1'b0;
  endtask

  task automatic test_streaming();
    bus.outs_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.ins = 32'h3B6 + 32'(i); bus.ins_valid = 1'b1;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
      #1;
      checks++; if (bus.outs !== 32'h3B6 + 32'(i) || bus.outs_valid !== 1'b1 || count !== 3'd0) begin failures++; $display("FAIL stream_bypass i=%0d got=%h v=%b cnt=%0d exp=%h", i, bus.outs, bus.outs_valid, count, 32'h3B6 + 32'(i)); end
      step();
`else
      step();
      checks++; if (bus.outs !== 32'h3B6 + 32'(i) || bus.outs_valid !== 1'b1) begin failures++; $display("FAIL stream_tok i=%0d got=%h v=%b exp=%h", i, bus.outs, bus.outs_valid, 32'h3B6 + 32'(i)); end
      checks++; if (count !== 3'd1) begin failures++; $display("FAIL stream_count i=%0d got=%0d exp=1", i, count); end
`endif
    end
    bus.ins_valid = 1'b0;
    step();
    checks++; if (count !== 3'd0 || bus.outs_valid !== 1'b0) begin failures++; $display("FAIL stream_end got cnt=%0d v=%b exp cnt=0 v=0", count, bus.outs_valid); end
    bus.outs_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [31:0] exp_tok [3];
    exp_tok[0] = 32'h012; exp_tok[1] = 32'h055; exp_tok[2] = 32'h013;
    bus.outs_ready = 1'b0; bus.ins_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ins = 32'h010 + 32'(i);
      step();
    end
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL sim_prefill got=%0d exp=3", count); end
    bus.ins = 32'h055; bus.outs_ready = 1'b1;
    step();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL sim_push_pop_count got=%0d exp=3", count); end
    checks++; if (bus.ins_ready !== 1'b1) begin failures++; $display("FAIL sim_push_pop_ready got=%b exp=1", bus.ins_ready); end
    checks++; if (bus.outs !== 32'h011) begin failures++; $display("FAIL sim_push_pop_head got=%h exp=011", bus.outs); end
    bus.ins = 32'h013; bus.outs_ready = 1'b0;
    step();
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL sim_full got=%0d exp=4", count); end
    bus.ins = 32'h0AA; bus.outs_ready = 1'b1;
    step();
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL sim_full_pop_only got=%0d exp=3", count); end
    bus.ins_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.outs !== exp_tok[i] || bus.outs_valid !== 1'b1) begin failures++; $display("FAIL sim_order i=%0d got=%h v=%b exp=%h", i, bus.outs, bus.outs_valid, exp_tok[i]); end
      step();
    end
    checks++; if (count !== 3'd0 || bus.outs_valid !== 1'b0) begin failures++; $display("FAIL sim_drained got cnt=%0d v=%b exp cnt=0 v=0", count, bus.outs_valid); end
    bus.outs_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    bus.outs_ready = 1'b0; bus.ins_valid = 1'b1;
    bus.ins = 32'h020; step();
    bus.ins = 32'h021; step();
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL mreset_prefill got=%0d exp=2", count); end
    bus.ins_valid = 1'b0; rst = 1'b0;
    step();
    checks++; if (count !== 3'd0 || bus.outs_valid !== 1'b0 || bus.outs !== 32'h0) begin failures++; $display("FAIL mreset_clear got cnt=%0d v=%b d=%h exp 0/0/0", count, bus.outs_valid, bus.outs); end
    rst = 1'b1;
    step();
    checks++; if (bus.outs_valid !== 1'b0) begin failures++; $display("FAIL mreset_after got v=%b exp=0", bus.outs_valid); end
    bus.ins = 32'h030; bus.ins_valid = 1'b1;
    step();
    bus.ins_valid = 1'b0;
    checks++; if (bus.outs !== 32'h030 || count !== 3'd1) begin failures++; $display("FAIL mreset_new_head got=%h cnt=%0d exp=030 cnt=1", bus.outs, count); end
    bus.outs_ready = 1'b1;
    step();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL mreset_drain got=%0d exp=0", count); end
    bus.outs_ready = 1'b0;
  endtask

  task automatic test_bypass();
    bus.ins = 32'h3B6; bus.ins_valid = 1'b1; bus.outs_ready = 1'b1;
    #1;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
    checks++; if (bus.outs !== 32'h3B6 || bus.outs_valid !== 1'b1) begin failures++; $display("FAIL bypass_same_cycle got=%h v=%b exp=3b6 v=1", bus.outs, bus.outs_valid); end
    step();
    bus.ins_valid = 1'b0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL bypass_count got=%0d exp=0", count); end
`else
    checks++; if (bus.outs_valid !== 1'b0 || bus.outs !== 32'h0) begin failures++; $display("FAIL nobypass_same_cycle got=%h v=%b exp=0 v=0", bus.outs, bus.outs_valid); end
    step();
    bus.ins_valid = 1'b0;
    checks++; if (bus.outs !== 32'h3B6 || count !== 3'd1) begin failures++; $display("FAIL nobypass_latency got=%h cnt=%0d exp=3b6 cnt=1", bus.outs, count); end
    step();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL nobypass_drain got=%0d exp=0", count); end
`endif
    bus.outs_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; bus.ins = '0; bus.ins_valid = 1'b0; bus.outs_ready = 1'b0;
    test_reset();
    test_fill_and_drain();
    test_streaming();
    test_simultaneous();
    test_mid_reset();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/handshake_fifo_buffer.md
# handshake_fifo_buffer

Elastic FIFO buffer on a valid/ready handshake channel. It sits directly downstream of a handshake constant stage: it captures the `outs` token stream and decouples the constant's consumer from backpressure. It stores up to DEPTH tokens in order and re-emits them on its own output channel. It holds no data semantics beyond strict FIFO ordering.

## Interface
- DATA_WIDTH, 32: token width in bits.
- DEPTH, 4: number of storage slots; legal values are 2 to 64.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous and active-low (state clears on a rising clk edge while rst=0).
- ins  input  DATA_WIDTH  input token data.
- ins_valid  input  1  input token present.
- ins_ready  output  1  buffer can accept a token this cycle.
- outs  output  DATA_WIDTH  head token data.
- outs_valid  output  1  head token present.
- outs_ready  input  1  consumer accepts the head token.
- count  output  clog2(DEPTH+1)  current occupancy.

## Operation
- Storage is a DEPTH-entry array with write pointer `wp`, read pointer `rp` and occupancy `count`.
- Push: `ins_valid && ins_ready` writes `ins` to slot `wp`. `wp` advances and wraps from DEPTH-1 to 0.
- Pop: `outs_valid && outs_ready` advances `rp`, with the same wrap rule.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop in the same cycle, or on neither.
- `ins_ready = rst && (count != DEPTH)`.
  - Independent of `outs_ready`, so there is no combinational path from output to input.
  - When full, a same-cycle pop does not admit a push.
- `outs_valid = (count != 0)`.
- `outs = mem[rp]` when `outs_valid=1`; `outs = 0` when `outs_valid=0`.
- Ordering is strict FIFO. No token is dropped or duplicated.
- Boundary cases:
  - Empty, push with no pop: count 0→1; `outs_valid` rises the next cycle.
  - Full: `ins_ready=0`; `ins_valid` is ignored and the input data is not sampled.
  - Count DEPTH-1 with push and pop together: count is unchanged and `ins_ready` stays 1.
  - Both pointers wrap: behaviour is identical across the wrap boundary.
  - `ins_valid` while `ins_ready=0`: the upstream stage must hold its token. The buffer does not check this.
- Reset (rst=0 at an edge) takes effect even mid-transfer:
  - `wp=rp=count=0`.
  - All stored tokens are discarded.
  - Memory contents are not cleared, but they are unobservable because `outs` is masked to 0.

## Timing
- Reset values: `outs_valid=0`, `outs=0`, `count=0`, `ins_ready=0` while rst=0.
- `ins_ready` becomes 1 in the first cycle with rst=1.
- Latency without bypass: a token pushed at edge N is visible on `outs` with `outs_valid=1` after edge N (1 cycle).
- Throughput: 1 token per cycle sustained when 0 < count < DEPTH.
- `ins_ready`, `outs_valid` and `outs` depend only on registered state; with bypass they also depend combinationally on the input channel (see Configuration).
- `count` is registered and reflects the state after the last edge.

## Configuration
- Macro `HANDSHAKE_FIFO_BYPASS_EN`.
- Defined (bypass mode):
  - When `count==0`: `outs_valid = ins_valid` and `outs = ins`, combinationally (0-cycle latency).
  - If `outs_ready=1` in that cycle, the token passes straight through and is not written; count stays 0.
  - If `outs_ready=0`, the token is written normally; count becomes 1.
- Not defined:
  - No combinational input-to-output path.
  - Minimum latency is 1 cycle, as described under Timing.

## Test plan
- Reset: hold rst=0 for 3 cycles while driving `ins_valid=1`, `ins=0x3B6` → `outs_valid=0`, `outs=0`, `count=0`, `ins_ready=0`. Release rst → `ins_ready=1` in the next cycle.
- Fill to full: DEPTH=4, `outs_ready=0`, push 0x3B6, 0x001, 0x002, 0x003 → count=4 and `ins_ready=0`. A 5th token (0x004) held on `ins` is not accepted.
- Drain in order: from the full state set `outs_ready=1` → `outs` shows 0x3B6, 0x001, 0x002, 0x003 on consecutive cycles. Then `outs_valid=0`, `outs=0`, count=0.
- Streaming and wrap: `ins_valid=1` and `outs_ready=1` continuously for 20 tokens (0x3B6 + i) → each token is output exactly once, in order, with one cycle of latency. Count stays 1 after the first cycle; pointers wrap 5 times.
- Simultaneous events:
  - At count=3, push 0x055 and pop in the same cycle → count stays 3 and 0x055 is emitted after the older tokens.
  - At count=4 with `outs_ready=1` → pop only, count goes to 3.
- Mid-operation reset and bypass:
  - With count=2, pulse rst=0 for 1 cycle → count=0 and `outs_valid=0`; old tokens never appear.
  - With `HANDSHAKE_FIFO_BYPASS_EN` defined, empty buffer, `ins=0x3B6`, `ins_valid=1`, `outs_ready=1` → `outs=0x3B6` and `outs_valid=1` in the same cycle, with count staying 0.
